// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg
// Shared definitions for the data-memory access controller and its helpers:
//   - access-size encodings (SIZE_BYTE / SIZE_HALF / SIZE_WORD / SIZE_BAD)
//   - controller FSM state type
//   - default memory window (base address and size in bytes)
//   - size_bytes(): number of bytes touched by an access size
// ============================================================================
package mem_access_pkg;

    localparam logic [31:0] DEF_MEM_BASE = 32'h8002_0000;
    localparam logic [31:0] DEF_MEM_SIZE = 32'h0010_0000;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Bytes covered by one access; the illegal encoding covers nothing.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// ============================================================================
// load_extend
// Combinational load-data formatter. Takes the raw right-justified word from
// memory and returns the architectural load value: byte and half loads use
// only the low 8 / 16 bits (the memory leaves the upper bytes stale) and are
// sign- or zero-extended; word loads pass through. Reused by instruction fetch.
// Ports:
//   size         in  2   access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   is_unsigned  in  1   1 = zero-extend byte/half, 0 = sign-extend
//   raw          in  32  data_out from memory
//   data         out 32  extended load result (0 for the illegal size)
// ============================================================================
module load_extend
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        data = '0;
        case (size)
            SIZE_BYTE: data = {{24{~is_unsigned & raw[7]}},  raw[7:0]};
            SIZE_HALF: data = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            SIZE_WORD: data = raw;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// Initiator side of the byte-addressed, big-endian data-memory port. Accepts
// one load/store from the MEM stage, rejects misaligned/illegal requests,
// drives the memory for one cycle (memory acts on the negedge), captures and
// extends load data, and returns it through a valid/ready response.
// At most one request is outstanding.
//
// Configuration macro: MEM_BOUNDS_CHECK_EN
//   defined     : requests touching bytes outside [MEM_BASE, MEM_BASE+MEM_SIZE)
//                 are faulted without a memory access.
//   not defined : only size and alignment are checked.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                       request fields
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_fault            response payload
//   mem_address, mem_data_in,
//   mem_write, mem_access_size      registered drive to memory
//   mem_data_out                    read data from memory
// ============================================================================
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = DEF_MEM_BASE,
    parameter logic [31:0] MEM_SIZE = DEF_MEM_SIZE
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,

    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out
);

    state_t      state;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic        req_fault;
    logic [31:0] ext_data;

`ifdef MEM_BOUNDS_CHECK_EN
    // 33-bit arithmetic so an access near 0xFFFF_FFFF cannot wrap into range.
    logic [32:0] req_last;
    logic [32:0] mem_last;
    logic        out_of_bounds;

    always_comb begin
        req_last      = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;
        mem_last      = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - 33'd1;
        out_of_bounds = (req_addr < MEM_BASE) || (req_last > mem_last);
    end
`endif

    // Request screening: illegal size or natural-alignment violation.
    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            SIZE_BYTE: req_fault = 1'b0;
            SIZE_HALF: req_fault = req_addr[0];
            SIZE_WORD: req_fault = |req_addr[1:0];
            default:   req_fault = 1'b1;
        endcase
`ifdef MEM_BOUNDS_CHECK_EN
        if (out_of_bounds) begin
            req_fault = 1'b1;
        end
`endif
    end

    load_extend u_load_extend (
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .raw         (mem_data_out),
        .data        (ext_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_fault       <= 1'b0;
            mem_write       <= 1'b0;
            mem_access_size <= SIZE_WORD;
            mem_address     <= MEM_BASE;
            mem_data_in     <= '0;
            lat_write       <= 1'b0;
            lat_size        <= SIZE_WORD;
            lat_unsigned    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write    <= req_write;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        req_ready    <= 1'b0;
                        if (req_fault) begin
                            // Rejected: memory outputs untouched so the idle
                            // address stays wherever it last pointed.
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= ST_RESP;
                        end else begin
                            mem_address     <= req_addr;
                            mem_data_in     <= req_wdata;
                            mem_access_size <= req_size;
                            mem_write       <= req_write;
                            state           <= ST_ACCESS;
                        end
                    end
                end

                ST_ACCESS: begin
                    // Memory acted on the negedge inside this cycle.
                    mem_write <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= lat_write ? 32'd0 : ext_data;
                    state     <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with a small big-endian byte memory that
// reads/writes on the negedge and, like the real part, only updates the low
// data_out bytes it accesses. Covers a 256-byte window at the memory base;
// accesses elsewhere read as zero and ignore writes.
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [31:0] BASE = 32'h8002_0000;
`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic BOUNDS_ON = 1'b1;
`else
    localparam logic BOUNDS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out = '0;

    int errors = 0;
    int checks = 0;
    int write_count = 0;

    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_fault       (rsp_fault),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_write       (mem_write),
        .mem_access_size (mem_access_size),
        .mem_data_out    (mem_data_out)
    );

    // Memory model: big-endian, acts on negedge.
    always @(negedge clk) begin
        logic [31:0] off;
        logic [31:0] nb;
        off = mem_address - BASE;
        nb  = (mem_access_size == 2'b00) ? 32'd1 : (mem_access_size == 2'b01) ? 32'd2 : 32'd4;
        if (mem_write === 1'b1) begin
            write_count++;
            if (off + nb <= 32'd256 && off < 32'd256) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < int'(nb)) mem[off[7:0] + 8'(i)] = mem_data_in[8*(int'(nb)-1-i) +: 8];
                end
            end
        end else begin
            if (off + nb <= 32'd256 && off < 32'd256) begin
                if (nb == 32'd1) mem_data_out[7:0] = mem[off[7:0]];
                else if (nb == 32'd2) mem_data_out[15:0] = {mem[off[7:0]], mem[off[7:0] + 8'd1]};
                else mem_data_out = {mem[off[7:0]], mem[off[7:0] + 8'd1],
                                     mem[off[7:0] + 8'd2], mem[off[7:0] + 8'd3]};
            end else begin
                if (nb == 32'd1) mem_data_out[7:0] = '0;
                else if (nb == 32'd2) mem_data_out[15:0] = '0;
                else mem_data_out = '0;
            end
        end
    end

    // Drives one request starting #1 after a posedge, waits (bounded) for the
    // response, reports it and completes the response handshake.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic fault, output int cycles);
        logic seen;
        rdata = '0;
        fault = 1'b0;
        cycles = 0;
        seen = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_size = sz;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wd;
        while (!seen && cycles < 8) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) req_valid = 1'b0;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: addr=%h no rsp_valid within %0d cycles", addr, cycles);
        end else begin
            rdata = rsp_rdata;
            fault = rsp_fault;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({req_ready, rsp_valid, rsp_fault, mem_write} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/vld/flt/wr=%b want 1000",
                     {req_ready, rsp_valid, rsp_fault, mem_write});
        end
        checks++;
        if (rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 00000000", rsp_rdata);
        end
        checks++;
        if (mem_address !== BASE || mem_access_size !== 2'b10 || mem_data_in !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem: got addr=%h size=%b din=%h want 80020000 10 00000000",
                     mem_address, mem_access_size, mem_data_in);
        end
    endtask

    task automatic test_word_byte_half();
        logic [31:0] rd;
        logic flt;
        int cyc;
        issue(1'b1, 2'b10, 1'b0, BASE, 32'h1122_3344, rd, flt, cyc);
        checks++;
        if (flt !== 1'b0 || rd !== 32'd0 || cyc != 2) begin
            errors++;
            $display("FAIL sw_rsp: got fault=%b rdata=%h lat=%0d want 0 00000000 2", flt, rd, cyc);
        end
        issue(1'b0, 2'b10, 1'b0, BASE, 32'd0, rd, flt, cyc);
        checks++;
        if (rd !== 32'h1122_3344 || flt !== 1'b0 || cyc != 2) begin
            errors++;
            $display("FAIL lw: got rdata=%h fault=%b lat=%0d want 11223344 0 2", rd, flt, cyc);
        end
        issue(1'b0, 2'b00, 1'b0, BASE, 32'd0, rd, flt, cyc);
        checks++;
        if (rd !== 32'h0000_0011) begin
            errors++;
            $display("FAIL lb_pos: got %h want 00000011", rd);
        end
        issue(1'b0, 2'b01, 1'b0, BASE + 32'd2, 32'd0, rd, flt, cyc);
        checks++;
        if (rd !== 32'h0000_3344) begin
            errors++;
            $display("FAIL lh_pos: got %h want 00003344", rd);
        end
    endtask

    task automatic test_extension();
        logic [31:0] rd;
        logic flt;
        int cyc;
        logic [31:0] exp_tab [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9000, 32'h0000_9000};
        logic [1:0]  sz_tab  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        uns_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] adr_tab [4] = '{32'h8002_0010, 32'h8002_0010, 32'h8002_0012, 32'h8002_0012};
        issue(1'b1, 2'b00, 1'b0, 32'h8002_0010, 32'h0000_0080, rd, flt, cyc);
        issue(1'b1, 2'b01, 1'b0, 32'h8002_0012, 32'h0000_9000, rd, flt, cyc);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sz_tab[i], uns_tab[i], adr_tab[i], 32'd0, rd, flt, cyc);
            checks++;
            if (rd !== exp_tab[i] || flt !== 1'b0) begin
                errors++;
                $display("FAIL ext_%0d: got rdata=%h fault=%b want %h 0", i, rd, flt, exp_tab[i]);
            end
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic flt;
        int cyc;
        int wc0;
        logic        wr_tab  [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  sz_tab  [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] adr_tab [3] = '{32'h8002_0002, 32'h8002_0001, 32'h8002_0000};
        wc0 = write_count;
        for (int i = 0; i < 3; i++) begin
            issue(wr_tab[i], sz_tab[i], 1'b0, adr_tab[i], 32'hA5A5_A5A5, rd, flt, cyc);
            checks++;
            if (flt !== 1'b1 || rd !== 32'd0 || cyc != 1) begin
                errors++;
                $display("FAIL fault_%0d: got fault=%b rdata=%h lat=%0d want 1 00000000 1",
                         i, flt, rd, cyc);
            end
        end
        checks++;
        if (write_count != wc0) begin
            errors++;
            $display("FAIL fault_no_write: got %0d writes want 0", write_count - wc0);
        end
        issue(1'b0, 2'b10, 1'b0, BASE, 32'd0, rd, flt, cyc);
        checks++;
        if (rd !== 32'h1122_3344) begin
            errors++;
            $display("FAIL fault_mem_kept: got %h want 11223344", rd);
        end
    endtask

    task automatic test_backpressure();
        logic seen;
        int cyc;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = BASE;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) req_valid = 1'b0;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_3344 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got vld=%b rdata=%h rdy=%b want 1 11223344 0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic flt;
        int cyc;
        issue(1'b1, 2'b10, 1'b0, BASE + 32'h20, 32'hCAFE_F00D, rd, flt, cyc);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b10;
        req_addr = BASE + 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_access: got mem_write=%b want 1", mem_write);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_clear: got wr=%b vld=%b rdy=%b want 0 0 1",
                     mem_write, rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 2'b10, 1'b0, BASE + 32'h20, 32'd0, rd, flt, cyc);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rst_mid_old: got %h want cafef00d", rd);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] rd;
        logic flt;
        int cyc;
        issue(1'b0, 2'b10, 1'b0, 32'h8012_0000, 32'd0, rd, flt, cyc);
        checks++;
        if (flt !== BOUNDS_ON || rd !== 32'd0) begin
            errors++;
            $display("FAIL bounds_above: got fault=%b rdata=%h want %b 00000000", flt, rd, BOUNDS_ON);
        end
        checks++;
        if (!BOUNDS_ON && mem_address !== 32'h8012_0000) begin
            errors++;
            $display("FAIL bounds_addr: got %h want 80120000", mem_address);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h8001_FFFF, 32'd0, rd, flt, cyc);
        checks++;
        if (flt !== BOUNDS_ON) begin
            errors++;
            $display("FAIL bounds_below: got fault=%b want %b", flt, BOUNDS_ON);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h8011_FFFC, 32'd0, rd, flt, cyc);
        checks++;
        if (flt !== 1'b0 || cyc != 2) begin
            errors++;
            $display("FAIL bounds_last_word: got fault=%b lat=%0d want 0 2", flt, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_word_byte_half();
        test_extension();
        test_faults();
        test_backpressure();
        test_reset_mid();
        test_bounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
